// File: rtl/sensor_classifier.sv
// Sensor front-end for the bin-positioning stepper: synchronises and debounces the three
// material sensors, accumulates sticky detections over a capture window, resolves one
// material class per object and hands it downstream with a valid/ack handshake.
module sensor_classifier #(
   parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500_000,
   parameter logic [31:0] CAPTURE_CYCLES  = 32'd25_000_000,
   parameter logic [31:0] CLEAR_CYCLES    = 32'd50_000_000,
   parameter logic [31:0] ACK_TIMEOUT     = 32'd1_000_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       capacitive,
   input  logic       inductive,
   input  logic       photo,
   output logic [1:0] class_code,
   output logic       class_valid,
   input  logic       class_ack,
   output logic       err_unknown,
   output logic       err_timeout,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle,
      StCapture,
      StDecide,
      StHold,
      StCooldown
   } state_e;

   // Raw sensor levels when nothing is present: capacitive is active low.
   localparam logic [2:0] RawInactive = 3'b100;

   // Bit order throughout: {capacitive, inductive, photo}.
   logic [2:0]       meta_q, sync_q;
   logic [2:0]       act;
   logic [2:0]       stable_q, stable_d;
   logic [2:0][31:0] db_cnt_q, db_cnt_d;
   logic             any_active;

   state_e           state_q, state_d;
   logic [31:0]      win_cnt_q, win_cnt_d;
   logic [31:0]      to_cnt_q, to_cnt_d;
   logic [31:0]      clr_cnt_q, clr_cnt_d;
   logic [2:0]       sticky_q, sticky_d;
   logic [1:0]       code_q, code_d;
   logic [1:0]       decoded;
   logic             valid_q, valid_d;
   logic             err_unk_q, err_unk_d;
   logic             err_to_q, err_to_d;

   // Two-flop synchroniser per raw input, reset to the inactive raw levels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RawInactive;
         sync_q <= RawInactive;
      end else begin
         meta_q <= {capacitive, inductive, photo};
         sync_q <= meta_q;
      end
   end

   // Normalise polarity so that 1 means "sensor active" from here on.
   assign act        = {~sync_q[2], sync_q[1:0]};
   assign any_active = |stable_q;

   // Debounce: stable follows act only after DEBOUNCE_CYCLES consecutive differing cycles.
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (act[i] == stable_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DEBOUNCE_CYCLES - 32'd1) begin
            stable_d[i] = act[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 32'd1;
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= '0;
         db_cnt_q <= '0;
      end else begin
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // Material lookup from the accumulated sticky flags; 00 marks an unsortable combination.
   always_comb begin
      decoded = 2'b00;
      case (sticky_q)
         3'b111:  decoded = 2'b01;  // metal
         3'b101:  decoded = 2'b10;  // plastic
         3'b100:  decoded = 2'b11;  // glass
         default: decoded = 2'b00;
      endcase
   end

   // Object FSM next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      to_cnt_d  = to_cnt_q;
      clr_cnt_d = clr_cnt_q;
      sticky_d  = sticky_q;
      code_d    = code_q;
      valid_d   = valid_q;
      err_unk_d = 1'b0;
      err_to_d  = 1'b0;

      case (state_q)
         StIdle: begin
            if (any_active) begin
               // The detection cycle itself is the first cycle of the window.
               sticky_d  = stable_q;
               win_cnt_d = 32'd1;
               state_d   = StCapture;
            end
         end
         StCapture: begin
            sticky_d = sticky_q | stable_q;
            if (win_cnt_q >= CAPTURE_CYCLES - 32'd1) begin
               state_d = StDecide;
            end else begin
               win_cnt_d = win_cnt_q + 32'd1;
            end
         end
         StDecide: begin
            to_cnt_d  = '0;
            clr_cnt_d = '0;
            if (decoded != 2'b00) begin
               code_d  = decoded;
               valid_d = 1'b1;
               state_d = StHold;
            end else begin
               err_unk_d = 1'b1;
               state_d   = StCooldown;
            end
         end
         StHold: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (class_ack) begin
               code_d    = 2'b00;
               valid_d   = 1'b0;
               clr_cnt_d = '0;
               state_d   = StCooldown;
            end else if (to_cnt_q == ACK_TIMEOUT - 32'd1) begin
               err_to_d  = 1'b1;
               code_d    = 2'b00;
               valid_d   = 1'b0;
               clr_cnt_d = '0;
               state_d   = StCooldown;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
         end
         StCooldown: begin
            if (any_active) begin
               clr_cnt_d = '0;
            end else if (clr_cnt_q == CLEAR_CYCLES - 32'd1) begin
               clr_cnt_d = '0;
               state_d   = StIdle;
            end else begin
               clr_cnt_d = clr_cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Object FSM state, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         win_cnt_q <= '0;
         to_cnt_q  <= '0;
         clr_cnt_q <= '0;
         sticky_q  <= '0;
         code_q    <= 2'b00;
         valid_q   <= 1'b0;
         err_unk_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_cnt_q <= win_cnt_d;
         to_cnt_q  <= to_cnt_d;
         clr_cnt_q <= clr_cnt_d;
         sticky_q  <= sticky_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         err_unk_q <= err_unk_d;
         err_to_q  <= err_to_d;
      end
   end

   assign class_code  = code_q;
   assign class_valid = valid_q;
   assign err_unknown = err_unk_q;
   assign err_timeout = err_to_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sensor_classifier.sv
// Self-checking bench for sensor_classifier with small timing parameters.
module tb_sensor_classifier;

   localparam int DEB   = 4;
   localparam int CAP   = 20;
   localparam int CLR   = 8;
   localparam int ACKTO = 50;
   // Raw edge -> sync (2) -> debounce -> window -> registered decision (1).
   localparam int LAT   = 2 + DEB + CAP + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       capacitive = 1'b1;
   logic       inductive = 1'b0;
   logic       photo = 1'b0;
   logic       class_ack = 1'b0;
   logic [1:0] class_code;
   logic       class_valid;
   logic       err_unknown;
   logic       err_timeout;
   logic       busy;

   int total = 0;
   int bad = 0;
   int valid_rises = 0;
   int exp_rises = 0;
   int unk_pulses = 0;
   int to_pulses = 0;

   sensor_classifier #(
      .DEBOUNCE_CYCLES(32'(DEB)),
      .CAPTURE_CYCLES (32'(CAP)),
      .CLEAR_CYCLES   (32'(CLR)),
      .ACK_TIMEOUT    (32'(ACKTO))
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .capacitive (capacitive),
      .inductive  (inductive),
      .photo      (photo),
      .class_code (class_code),
      .class_valid(class_valid),
      .class_ack  (class_ack),
      .err_unknown(err_unknown),
      .err_timeout(err_timeout),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge class_valid) valid_rises++;
   always @(posedge clk) begin
      if (err_unknown === 1'b1) unk_pulses++;
      if (err_timeout === 1'b1) to_pulses++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   // Expected material from the set of sensors that saw the object.
   function automatic logic [1:0] model_class(input logic c, input logic i, input logic p);
      if (c && i && p) return 2'b01;
      if (c && !i && p) return 2'b10;
      if (c && !i && !p) return 2'b11;
      return 2'b00;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic i, input logic p);
      capacitive = ~c;
      inductive  = i;
      photo      = p;
   endtask

   task automatic pulse_ack();
      class_ack = 1'b1;
      tick();
      class_ack = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Presents an object and returns cycles from the raw edge to valid/err_unknown.
   // gsel: 0 none, 1 inductive, 2 photo pulse high during [gon, goff).
   task automatic present(input logic c, input logic i, input logic p, input int gsel,
                          input int gon, input int goff, input int rel, input int ackp,
                          output int n);
      drive(c, i, p);
      n = 0;
      while (!class_valid && !err_unknown && n < 100) begin
         tick();
         n++;
         class_ack = (n == ackp);
         if (gsel == 1 && n == gon) inductive = 1'b1;
         if (gsel == 1 && n == goff) inductive = 1'b0;
         if (gsel == 2 && n == gon) photo = 1'b1;
         if (gsel == 2 && n == goff) photo = 1'b0;
         if (n == rel) drive(1'b0, 1'b0, 1'b0);
      end
      class_ack = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++; if (class_code !== 2'b00) begin bad++; $display("FAIL reset_code got=%b want=00", class_code); end
      total++; if (class_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", class_valid); end
      total++; if (err_unknown !== 1'b0) begin bad++; $display("FAIL reset_err_unknown got=%b want=0", err_unknown); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err_timeout got=%b want=0", err_timeout); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_metal();
      int n, d, m;
      present(1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, n);
      total++; if (n != LAT) begin bad++; $display("FAIL metal_latency got=%0d want=%0d", n, LAT); end
      total++; if (class_code !== 2'b01) begin bad++; $display("FAIL metal_code got=%b want=01", class_code); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL metal_busy got=%b want=1", busy); end
      exp_rises++;
      repeat (30 - LAT) tick();
      drive(1'b0, 1'b0, 1'b0);
      d = $urandom_range(8, 15);
      repeat (d) tick();
      total++; if (class_valid !== 1'b1 || class_code !== 2'b01) begin
         bad++; $display("FAIL metal_hold got=%b/%b want=1/01", class_valid, class_code);
      end
      pulse_ack();
      total++; if (class_valid !== 1'b0 || class_code !== 2'b00) begin
         bad++; $display("FAIL metal_ack_clear got=%b/%b want=0/00", class_valid, class_code);
      end
      // Sensors are already quiet, so cooldown lasts exactly CLR cycles after the ack.
      m = 0;
      while (busy && m < 100) begin
         tick();
         m++;
      end
      total++; if (m != CLR) begin bad++; $display("FAIL metal_cooldown got=%0d want=%0d", m, CLR); end
   endtask

   task automatic test_plastic_glass();
      int n;
      bit ok;
      logic [1:0] want;
      for (int k = 0; k < 4; k++) begin
         // 0 plastic, 1 glass, 2 late photo pulse (sticky), 3 glass with inductive glitch
         case (k)
            0: present(1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, n);
            1: present(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, n);
            2: present(1'b1, 1'b0, 1'b0, 2, 10, 16, 0, 0, n);
            default: present(1'b1, 1'b0, 1'b0, 1, 8, 11, 0, 0, n);
         endcase
         want = (k == 0 || k == 2) ? 2'b10 : 2'b11;
         total++; if (n != LAT) begin bad++; $display("FAIL pg%0d_latency got=%0d want=%0d", k, n, LAT); end
         total++; if (class_code !== want) begin
            bad++; $display("FAIL pg%0d_code got=%b want=%b", k, class_code, want);
         end
         exp_rises++;
         repeat (3) tick();
         drive(1'b0, 1'b0, 1'b0);
         repeat ($urandom_range(1, 10)) tick();
         pulse_ack();
         total++; if (class_valid !== 1'b0) begin bad++; $display("FAIL pg%0d_ack got=%b want=0", k, class_valid); end
         wait_idle(ok);
         total++; if (!ok) begin bad++; $display("FAIL pg%0d_idle got=busy want=idle", k); end
      end
   endtask

   task automatic test_unknown();
      int n, m, u0;
      u0 = unk_pulses;
      present(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, n);
      total++; if (n != LAT || err_unknown !== 1'b1) begin
         bad++; $display("FAIL unk_pulse got=%0d/%b want=%0d/1", n, err_unknown, LAT);
      end
      total++; if (class_valid !== 1'b0) begin bad++; $display("FAIL unk_valid got=%b want=0", class_valid); end
      tick();
      total++; if (err_unknown !== 1'b0) begin bad++; $display("FAIL unk_single got=%b want=0", err_unknown); end
      drive(1'b0, 1'b0, 1'b0);
      m = 0;
      while (busy && m < 100) begin
         tick();
         m++;
      end
      total++; if (m != 2 + DEB + CLR) begin
         bad++; $display("FAIL unk_cooldown got=%0d want=%0d", m, 2 + DEB + CLR);
      end
      total++; if (unk_pulses - u0 != 1) begin
         bad++; $display("FAIL unk_count got=%0d want=1", unk_pulses - u0);
      end
   endtask

   task automatic test_timeout();
      int n, m;
      bit ok;
      present(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, n);
      exp_rises++;
      drive(1'b0, 1'b0, 1'b0);
      m = 0;
      while (class_valid && m < 100) begin
         tick();
         m++;
      end
      total++; if (m != ACKTO) begin bad++; $display("FAIL timeout_len got=%0d want=%0d", m, ACKTO); end
      total++; if (err_timeout !== 1'b1 || class_code !== 2'b00) begin
         bad++; $display("FAIL timeout_pulse got=%b/%b want=1/00", err_timeout, class_code);
      end
      tick();
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_single got=%b want=0", err_timeout); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL timeout_idle got=busy want=idle"); end
   endtask

   task automatic test_ack_at_timeout();
      int n, t0;
      bit ok;
      t0 = to_pulses;
      present(1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, n);
      exp_rises++;
      drive(1'b0, 1'b0, 1'b0);
      repeat (ACKTO - 1) tick();
      total++; if (class_valid !== 1'b1) begin bad++; $display("FAIL ackto_pre got=%b want=1", class_valid); end
      pulse_ack();
      total++; if (class_valid !== 1'b0 || err_timeout !== 1'b0) begin
         bad++; $display("FAIL ackto_result got=%b/%b want=0/0", class_valid, err_timeout);
      end
      wait_idle(ok);
      total++; if (!ok || to_pulses != t0) begin
         bad++; $display("FAIL ackto_no_err got=%0d want=0", to_pulses - t0);
      end
   endtask

   task automatic test_reset_mid_hold();
      int n, r0;
      present(1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, n);
      exp_rises++;
      drive(1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(1, 20)) tick();
      #2 rst_n = 1'b0;
      #1;
      total++; if (class_valid !== 1'b0 || class_code !== 2'b00 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_hold got=%b/%b/%b want=0/00/0", class_valid, class_code, busy);
      end
      tick();
      repeat (2) tick();
      rst_n = 1'b1;
      r0 = valid_rises;
      repeat (40) tick();
      total++; if (valid_rises != r0 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_no_pending got=%0d/%b want=0/0", valid_rises - r0, busy);
      end
   endtask

   task automatic test_random();
      int n, rel, ackp;
      bit ok;
      logic c, i, p;
      logic [1:0] want;
      for (int it = 0; it < 8; it++) begin
         c = 1'($urandom_range(0, 1));
         i = 1'($urandom_range(0, 1));
         p = 1'($urandom_range(0, 1));
         if (!c && !i && !p) c = 1'b1;
         rel  = $urandom_range(8, 34);
         ackp = $urandom_range(1, 20);  // stray ack before any decision
         want = model_class(c, i, p);
         present(c, i, p, 0, 0, 0, rel, ackp, n);
         drive(1'b0, 1'b0, 1'b0);
         total++; if (n != LAT) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", it, n, LAT); end
         if (want != 2'b00) begin
            exp_rises++;
            total++; if (class_valid !== 1'b1 || class_code !== want) begin
               bad++; $display("FAIL rnd%0d_code got=%b/%b want=1/%b", it, class_valid, class_code, want);
            end
            // Unrelated sensor activity while holding must not disturb the result.
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 10)) tick();
            drive(1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(1, 20)) tick();
            total++; if (class_valid !== 1'b1 || class_code !== want) begin
               bad++; $display("FAIL rnd%0d_hold got=%b/%b want=1/%b", it, class_valid, class_code, want);
            end
            pulse_ack();
            total++; if (class_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_ack got=%b want=0", it, class_valid); end
         end else begin
            total++; if (err_unknown !== 1'b1 || class_valid !== 1'b0) begin
               bad++; $display("FAIL rnd%0d_unknown got=%b/%b want=1/0", it, err_unknown, class_valid);
            end
         end
         wait_idle(ok);
         total++; if (!ok) begin bad++; $display("FAIL rnd%0d_idle got=busy want=idle", it); end
      end
   endtask

   initial begin
      test_reset();
      test_metal();
      test_plastic_glass();
      test_unknown();
      test_timeout();
      test_ack_at_timeout();
      test_random();
      test_reset_mid_hold();
      total++; if (valid_rises != exp_rises) begin
         bad++; $display("FAIL valid_count got=%0d want=%0d", valid_rises, exp_rises);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sensor_classifier.md
Name: sensor_classifier

Overview:
- Upstream front-end for the bin-positioning stepper stage.
- Synchronises and debounces the capacitive, inductive and photo sensors, and accumulates sticky detections over a fixed capture window.
- Resolves one material class per object and hands it downstream with a valid/ack handshake.
- Replaces raw sensor wiring into the stepper, so each object produces exactly one sort command.

Parameters:
- DEBOUNCE_CYCLES, 32'd500_000: cycles a synchronised input must differ from its stable value before the stable value updates.
- CAPTURE_CYCLES, 32'd25_000_000: length of the detection accumulation window after first activity.
- CLEAR_CYCLES, 32'd50_000_000: cycles all sensors must be continuously inactive before a new object is accepted.
- ACK_TIMEOUT, 32'd1_000_000_000: maximum cycles in HOLD before abandoning the command.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- capacitive, input, 1: raw capacitive sensor, active low.
- inductive, input, 1: raw inductive sensor, active high.
- photo, input, 1: raw photo sensor, active high.
- class_code, output, 2: material class. 01 = metal, 10 = plastic, 11 = glass; 00 only when class_valid = 0.
- class_valid, output, 1: class_code is valid; held until acknowledged.
- class_ack, input, 1: one-cycle pulse from the stepper when its sort cycle is complete.
- err_unknown, output, 1: one-cycle pulse when an object yields an unsortable sensor combination.
- err_timeout, output, 1: one-cycle pulse when ACK_TIMEOUT expires in HOLD.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset (async, rst_n = 0):
  - Outputs: class_code = 00, class_valid = 0, err_unknown = 0, err_timeout = 0, busy = 0.
  - Internal: sync flops cleared to the inactive level (capacitive = 1, others = 0); stable values inactive; all counters 0; sticky flags 0; state IDLE.
- Synchronisation: 2-flop synchroniser per input. Internally, capacitive is inverted so that 1 means active.
- Debounce (per input):
  - 32-bit counter increments while synced != stable and clears on any cycle where synced == stable.
  - When the counter reaches DEBOUNCE_CYCLES-1 with inputs still differing, stable updates on the next edge and the counter clears.
  - Latency from a raw edge to the stable edge is 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES cycles never reach stable.
- any_active = OR of the three stable values.
- FSM states:
  - IDLE:
    - When any_active = 1: clear the sticky flags, load the window counter, go to CAPTURE.
    - The sticky flags are set this same cycle from the current stable values.
  - CAPTURE:
    - Each cycle: cap_s |= stable_cap, ind_s |= stable_ind, pho_s |= stable_pho.
    - Window counter counts CAPTURE_CYCLES cycles in total, including the entry cycle, then go to DECIDE.
  - DECIDE (1 cycle):
    - cap & ind & pho -> 01; cap & !ind & pho -> 10; cap & !ind & !pho -> 11.
    - Any valid class: register class_code, set class_valid, go to HOLD.
    - Any other combination: pulse err_unknown, go to COOLDOWN.
  - HOLD:
    - class_valid = 1 and class_code stable.
    - On class_ack = 1: class_valid and class_code clear on the next edge, go to COOLDOWN.
    - If the timeout counter reaches ACK_TIMEOUT-1 without ack: pulse err_timeout, clear class_valid and class_code, go to COOLDOWN.
    - Ack and timeout in the same cycle: ack wins, no error.
  - COOLDOWN:
    - Clear counter increments while any_active = 0 and resets to 0 whenever any_active = 1.
    - After CLEAR_CYCLES consecutive inactive cycles, go to IDLE.
- Boundary rules:
  - class_ack outside HOLD is ignored.
  - Sensor activity during HOLD or COOLDOWN never alters class_code or starts a new capture.
  - Exactly one class_valid assertion per object.
- rst_n asserted mid-operation: immediate return to reset values, including a dropped class_valid. No pending result survives reset.
- All counters are 32-bit unsigned. Comparisons use the parameter minus 1, so a parameter value of 1 means a single cycle.

Test Plan:
- Bench parameters: DEBOUNCE = 4, CAPTURE = 20, CLEAR = 8, ACK_TIMEOUT = 50.
- Metal: capacitive = 0, inductive = 1, photo = 1 held 30 cycles -> class_code = 01, class_valid rises 2+4+20+1 cycles after the raw edge. Ack pulse -> valid = 0 next cycle; busy = 0 after sensors idle 8 cycles.
- Plastic and glass:
  - Plastic: capacitive = 0, photo = 1, inductive = 0 -> 10.
  - Glass: capacitive = 0 only -> 11.
  - Photo pulse arriving 10 cycles into the window still yields 10 (sticky).
- Glitch: inductive high for 3 cycles during a glass object -> class stays 11.
- Unknown: photo alone for 30 cycles -> err_unknown pulses once, class_valid stays 0, FSM returns to IDLE after 8 clear cycles.
- Timeout and reset:
  - No ack for 50 HOLD cycles -> err_timeout pulse, valid = 0.
  - Separate run: rst_n low mid-HOLD -> valid = 0 immediately (async).
  - Ack in the same cycle the timeout expires -> no err_timeout.
